// File: rtl/bram_pkg.sv
// Shared types and constants for the byte-enable pipelined block RAM.
package bram_pkg;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam int READ_LATENCY_1 = 1;
    localparam int READ_LATENCY_2 = 2;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_init_sequencer.sv
// Post-reset zero-fill sweep: walks every address once, then holds S_READY
// until the next reset. With INIT_MODE=0 it comes out of reset already ready.
module bram_init_sequencer
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int INIT_MODE  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  clearWrite,
    output logic [ADDR_WIDTH-1:0] clearAddress,
    output logic                  initDone
);

    localparam logic [ADDR_WIDTH:0] CNT_LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam state_t              RST_STATE = (INIT_MODE == 1) ? S_CLEAR : S_READY;

    state_t                state;
    logic   [ADDR_WIDTH:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else if (state == S_CLEAR) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
                state <= S_READY;
            end
        end
    end

    assign clearWrite   = (state == S_CLEAR);
    assign clearAddress = cnt[ADDR_WIDTH-1:0];
    assign initDone     = (state == S_READY);

endmodule

// File: rtl/bram_be_pipelined.sv
// Simple dual-port block RAM with per-byte write enables, same-cycle
// read-during-write bypass, 1/2-cycle read latency and optional zero-fill.
module bram_be_pipelined
    import bram_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 8,
    parameter int    BYTE_WIDTH   = 8,
    parameter int    READ_LATENCY = 1,
    parameter int    INIT_MODE    = 0,
    parameter string INIT_FILE    = "",
    localparam int   NUM_BYTES    = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  readValid,
    input  logic                  writeEnable,
    input  logic [NUM_BYTES-1:0]  writeByteEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  initDone
);

    if (READ_LATENCY != READ_LATENCY_1 && READ_LATENCY != READ_LATENCY_2) begin : g_bad_latency
        $error("bram_be_pipelined: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("bram_be_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    logic                  clear_write;
    logic [ADDR_WIDTH-1:0] clear_address;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]  wr_mask;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_merged;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;

    bram_init_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_MODE  (INIT_MODE)
    ) u_init (
        .clock        (clock),
        .reset        (reset),
        .clearWrite   (clear_write),
        .clearAddress (clear_address),
        .initDone     (initDone)
    );

    // The sweep owns the write port until initDone; user traffic is dropped.
    assign wr_en   = clear_write | (initDone & writeEnable);
    assign wr_addr = clear_write ? clear_address : writeAddress;
    assign wr_data = clear_write ? '0 : writeData;
    assign wr_mask = clear_write ? '1 : writeByteEnable;
    assign rd_req  = initDone & readEnable;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_mask[i]) begin
                    ram[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_merged = ram[readAddress];
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_en && wr_addr == readAddress && wr_mask[i]) begin
                rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Stage 1: array read with issue-cycle bypass
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            data_p1 <= rd_req ? rd_merged : '0;
            vld_p1  <= rd_req;
        end
    end

    if (READ_LATENCY == READ_LATENCY_2) begin : g_lat2
        logic [DATA_WIDTH-1:0] data_p2;
        logic                  vld_p2;

        // Stage 2: output register, no further bypass
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                data_p2 <= '0;
                vld_p2  <= 1'b0;
            end else begin
                data_p2 <= data_p1;
                vld_p2  <= vld_p1;
            end
        end

        assign readData  = data_p2;
        assign readValid = vld_p2;
    end else begin : g_lat1
        assign readData  = data_p1;
        assign readValid = vld_p1;
    end

endmodule

// File: tb/tb_bram_be_pipelined.sv
// Bench for bram_be_pipelined: latency-1 and latency-2 instances, both with
// zero-fill, driven by identical stimulus and compared to a word-array model.
module tb_bram_be_pipelined;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        read_enable = 1'b0;
    logic [3:0]  read_address = '0;
    logic        write_enable = 1'b0;
    logic [3:0]  write_byte_enable = '0;
    logic [3:0]  write_address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data1, read_data2;
    logic        read_valid1, read_valid2;
    logic        init_done1, init_done2;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [16];
    int          cycles_m;
    bit          ready_m;
    logic [31:0] prev_d;
    bit          prev_v;

    always #5 clock = ~clock;

    bram_be_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .INIT_MODE(1), .INIT_FILE("")
    ) dut1 (
        .clock(clock), .reset(reset),
        .readEnable(read_enable), .readAddress(read_address),
        .readData(read_data1), .readValid(read_valid1),
        .writeEnable(write_enable), .writeByteEnable(write_byte_enable),
        .writeAddress(write_address), .writeData(write_data),
        .initDone(init_done1)
    );

    bram_be_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .INIT_MODE(1), .INIT_FILE("")
    ) dut2 (
        .clock(clock), .reset(reset),
        .readEnable(read_enable), .readAddress(read_address),
        .readData(read_data2), .readValid(read_valid2),
        .writeEnable(write_enable), .writeByteEnable(write_byte_enable),
        .writeAddress(write_address), .writeData(write_data),
        .initDone(init_done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive, predict from the model, advance, compare both instances.
    task automatic step(input bit re, input logic [3:0] ra, input bit we,
                        input logic [3:0] wbe, input logic [3:0] wa, input logic [31:0] wd);
        logic [31:0] ed;
        bit          ev;
        read_enable       = re;
        read_address      = ra;
        write_enable      = we;
        write_byte_enable = wbe;
        write_address     = wa;
        write_data        = wd;
        ev = ready_m && re;
        ed = '0;
        if (ev) begin
            ed = mem_m[ra];
            if (we && wa == ra)
                for (int i = 0; i < 4; i++)
                    if (wbe[i]) ed[i*8 +: 8] = wd[i*8 +: 8];
        end
        if (ready_m && we)
            for (int i = 0; i < 4; i++)
                if (wbe[i]) mem_m[wa][i*8 +: 8] = wd[i*8 +: 8];
        @(posedge clock);
        #1;
        if (!ready_m) begin
            cycles_m++;
            if (cycles_m == 16) begin
                ready_m = 1'b1;
                foreach (mem_m[j]) mem_m[j] = '0;
            end
        end
        chk("init_done1", init_done1, ready_m);
        chk("init_done2", init_done2, ready_m);
        chk("valid_lat1", read_valid1, ev);
        chk("data_lat1", read_data1, ed);
        chk("valid_lat2", read_valid2, prev_v);
        chk("data_lat2", read_data2, prev_d);
        prev_v = ev;
        prev_d = ed;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        read_enable  = 1'b0;
        write_enable = 1'b0;
        reset        = 1'b0;
        #2;
        chk("rst_async_data1", read_data1, 32'h0);
        chk("rst_async_valid1", read_valid1, 32'h0);
        chk("rst_async_data2", read_data2, 32'h0);
        chk("rst_async_valid2", read_valid2, 32'h0);
        chk("rst_async_init1", init_done1, 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_hold_init2", init_done2, 32'h0);
        chk("rst_hold_valid1", read_valid1, 32'h0);
        reset    = 1'b1;
        cycles_m = 0;
        ready_m  = 1'b0;
        prev_d   = '0;
        prev_v   = 1'b0;
    endtask

    initial begin
        logic [3:0]  ra, wa;
        logic [31:0] wd;

        do_reset();

        // Sweep: initDone low for 16 edges, then high; writes are ignored
        for (int c = 0; c < 16; c++) begin
            if (c < 15) chk("sweep_busy", init_done1, 32'h0);
            step(1'b1, 4'(c), 1'b1, 4'hF, 4'(c), 32'h5A5A0000 + 32'(c));
        end
        chk("sweep_done", init_done1, 32'h1);
        for (int a = 0; a < 16; a++) begin
            step(1'b1, 4'(a), 1'b0, 4'h0, 4'h0, 32'h0);
            chk("zero_fill", read_data1, 32'h0);
            chk("zero_fill_valid", read_valid1, 32'h1);
        end

        // Partial byte-mask overwrite
        step(1'b0, 4'h0, 1'b1, 4'hF, 4'h5, 32'hDEADBEEF);
        step(1'b0, 4'h0, 1'b1, 4'b0101, 4'h5, 32'h11223344);
        step(1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 32'h0);
        chk("byte_mask", read_data1, 32'hDE22BE44);

        // Same-cycle read/write bypass merged per byte
        step(1'b0, 4'h0, 1'b1, 4'hF, 4'h7, 32'h01020304);
        step(1'b1, 4'h7, 1'b1, 4'b1100, 4'h7, 32'hCAFEF00D);
        chk("bypass", read_data1, 32'hCAFE0304);

        // Latency 2: write after issue does not touch the in-flight result
        step(1'b0, 4'h0, 1'b1, 4'hF, 4'h3, 32'hAAAA5555);
        step(1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 32'h0);
        step(1'b0, 4'h0, 1'b1, 4'hF, 4'h3, 32'h0);
        chk("lat2_inflight_valid", read_valid2, 32'h1);
        chk("lat2_inflight", read_data2, 32'hAAAA5555);
        step(1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 32'h0);
        idle();
        chk("lat2_followup", read_data2, 32'h0);
        chk("lat2_followup_valid", read_valid2, 32'h1);

        // Back-to-back reads, then an idle cycle
        for (int a = 0; a < 4; a++)
            step(1'b0, 4'h0, 1'b1, 4'hF, 4'(a), 32'h10 + 32'(a));
        for (int a = 0; a < 4; a++) begin
            step(1'b1, 4'(a), 1'b0, 4'h0, 4'h0, 32'h0);
            chk("b2b", read_data1, 32'h10 + 32'(a));
        end
        idle();
        chk("idle_data", read_data1, 32'h0);
        chk("idle_valid", read_valid1, 32'h0);

        // Random traffic with frequent same-address collisions
        for (int n = 0; n < 400; n++) begin
            ra = 4'($urandom_range(0, 15));
            wa = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
            wd = $urandom;
            step(bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), wa, wd);
        end

        // Reset with a read in flight, then reset again mid-sweep
        step(1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 32'h0);
        do_reset();
        for (int c = 0; c < 9; c++)
            step(1'b1, 4'(c), 1'b1, 4'hF, 4'(c), 32'hFFFFFFFF);
        do_reset();
        for (int c = 0; c < 16; c++)
            step(1'b0, 4'h0, 1'b1, 4'hF, 4'h2, 32'h12345678);
        chk("resweep_done", init_done2, 32'h1);
        for (int a = 0; a < 16; a++) begin
            step(1'b1, 4'(a), 1'b0, 4'h0, 4'h0, 32'h0);
            chk("resweep_zero", read_data1, 32'h0);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
